// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the ID stage and the register file: read ports, WB lanes
// and the load scoreboard set request.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned NUM_WR = 2;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_use;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     stall;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, rd_use, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_busy, stall, pend_cnt
  );

  modport slave (
    input  rd_addr, rd_use, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_busy, stall, pend_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file for ID: combinational reads with write-first bypass
// from both WB lanes, plus a pending-load scoreboard that raises stall.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_mp_sb_if.slave  bus
);
  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned NUM_WR = 2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic [ADDR_W-1:0] wr_addr_c [NUM_WR];
  logic [DATA_W-1:0] wr_data_c [NUM_WR];
  logic [NUM_WR-1:0] wr_ok_c;
  logic [DEPTH-1:0]  clr_mask_c;
  logic [DEPTH-1:0]  set_mask_c;
  logic [DEPTH-1:0]  clr_eff_c;
  logic              inc_c;
  logic [CNT_W-1:0]  dec_c;

  logic [ADDR_W-1:0]        rd_addr_c [NUM_RD];
  logic [DATA_W-1:0]        rd_word_c [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic                     stall_c;

  // Write lane decode; a write to the hardwired zero register never qualifies.
  always_comb begin
    clr_mask_c = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_addr_c[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
      wr_data_c[j] = bus.wr_data[j*DATA_W +: DATA_W];
      wr_ok_c[j]   = bus.wr_en[j] && !(ZERO_REG && (wr_addr_c[j] == '0));
      if (wr_ok_c[j]) clr_mask_c[wr_addr_c[j]] = 1'b1;
    end
  end

  always_comb begin
    set_mask_c = '0;
    if (bus.sb_set && !(ZERO_REG && (bus.sb_addr == '0)))
      set_mask_c[bus.sb_addr] = 1'b1;
  end

  // Lane 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok_c[j]) mem_d[wr_addr_c[j]] = wr_data_c[j];
    end
  end

  // Set beats clear on the same register: the younger load is still outstanding.
  always_comb begin
    pend_d    = (pend_q & ~clr_mask_c) | set_mask_c;
    clr_eff_c = pend_q & clr_mask_c & ~set_mask_c;
    inc_c     = |(set_mask_c & ~pend_q);
    dec_c     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dec_c = dec_c + CNT_W'(clr_eff_c[k]);
    end
    pend_cnt_d = pend_cnt_q + CNT_W'(inc_c) - dec_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Read ports: zero register, then same-cycle writeback bypass, then array.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_c[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd_word_c[i] = mem_q[rd_addr_c[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok_c[j] && (wr_addr_c[j] == rd_addr_c[i])) rd_word_c[i] = wr_data_c[j];
      end
      rd_busy_c[i] = pend_q[rd_addr_c[i]] & ~clr_mask_c[rd_addr_c[i]];
      if (ZERO_REG && (rd_addr_c[i] == '0)) begin
        rd_word_c[i] = '0;
        rd_busy_c[i] = 1'b0;
      end
      rd_data_c[i*DATA_W +: DATA_W] = rd_word_c[i];
    end
    stall_c = |(rd_busy_c & bus.rd_use);
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.stall    = stall_c;
  assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass, lane priority, zero register,
// scoreboard set/clear interplay and reset while loads are pending.
module tb_regfile_mp_sb;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr = '0;
    bus.rd_use  = '0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
  endtask

  task automatic sb_mark(input logic [4:0] a);
    idle();
    bus.sb_set  = 1'b1;
    bus.sb_addr = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.pend_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_pend_cnt: got %0d expected 0", bus.pend_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(31 - a), 5'(a)};
      bus.rd_use  = 2'b11;
      #1;
      n_checks++;
      if (bus.rd_data !== 64'h0) begin
        n_fail++; $display("FAIL reset_rd_data r%0d: got %h expected 0", a, bus.rd_data);
      end
      n_checks++;
      if (bus.rd_busy !== 2'b00 || bus.stall !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy r%0d: got busy %b stall %b expected 00/0", a, bus.rd_busy, bus.stall);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.wr_en        = 2'b01;
    bus.wr_addr[4:0] = 5'd5;
    bus.wr_data[31:0] = 32'hDEADBEEF;
    bus.rd_addr[4:0] = 5'd5;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", bus.rd_data[31:0]);
    end
    step();
    idle();
    bus.rd_addr[4:0] = 5'd5;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_array: got %h expected deadbeef", bus.rd_data[31:0]);
    end
  endtask

  task automatic test_lane_priority();
    idle();
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {32'h22, 32'h11};
    bus.rd_addr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (bus.rd_data !== {32'h22, 32'h22}) begin
      n_fail++; $display("FAIL lane_bypass: got %h expected 00000022 both ports", bus.rd_data);
    end
    step();
    idle();
    bus.rd_addr[9:5] = 5'd7;
    #1;
    n_checks++;
    if (bus.rd_data[63:32] !== 32'h22) begin
      n_fail++; $display("FAIL lane_priority: got %h expected 00000022", bus.rd_data[63:32]);
    end
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd0;
    bus.wr_data[31:0] = 32'hFFFF;
    bus.rd_addr[4:0]  = 5'd0;
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL r0_bypass: got %h expected 0", bus.rd_data[31:0]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL r0_array: got %h expected 0", bus.rd_data[31:0]);
    end
    sb_mark(5'd0);
    n_checks++;
    if (bus.pend_cnt !== 6'd0 || bus.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL r0_pending: got cnt %0d busy %b expected 0/00", bus.pend_cnt, bus.rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    sb_mark(5'd9);
    bus.rd_addr[9:5] = 5'd9;
    bus.rd_use       = 2'b10;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1 || bus.rd_busy !== 2'b10 || bus.pend_cnt !== 6'd1) begin
      n_fail++; $display("FAIL sb_stall: got stall %b busy %b cnt %0d expected 1/10/1", bus.stall, bus.rd_busy, bus.pend_cnt);
    end
    bus.wr_en          = 2'b10;
    bus.wr_addr[9:5]   = 5'd9;
    bus.wr_data[63:32] = 32'h55;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_data[63:32] !== 32'h55) begin
      n_fail++; $display("FAIL sb_release: got stall %b data %h expected 0/00000055", bus.stall, bus.rd_data[63:32]);
    end
    step();
    idle();
    n_checks++;
    if (bus.pend_cnt !== 6'd0) begin
      n_fail++; $display("FAIL sb_clear_cnt: got %0d expected 0", bus.pend_cnt);
    end
  endtask

  task automatic test_set_clear_same();
    sb_mark(5'd9);
    bus.sb_set         = 1'b1;
    bus.sb_addr        = 5'd9;
    bus.wr_en          = 2'b01;
    bus.wr_addr[4:0]   = 5'd9;
    bus.wr_data[31:0]  = 32'h66;
    bus.rd_addr[9:5]   = 5'd9;
    bus.rd_use         = 2'b10;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_data[63:32] !== 32'h66) begin
      n_fail++; $display("FAIL setclr_same_cycle: got stall %b data %h expected 0/00000066", bus.stall, bus.rd_data[63:32]);
    end
    step();
    idle();
    bus.rd_addr[9:5] = 5'd9;
    bus.rd_use       = 2'b10;
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd1 || bus.stall !== 1'b1 || bus.rd_data[63:32] !== 32'h66) begin
      n_fail++; $display("FAIL setclr_after: got cnt %0d stall %b data %h expected 1/1/00000066", bus.pend_cnt, bus.stall, bus.rd_data[63:32]);
    end
    bus.rd_use = 2'b00;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_busy !== 2'b10) begin
      n_fail++; $display("FAIL unused_busy: got stall %b busy %b expected 0/10", bus.stall, bus.rd_busy);
    end
    sb_mark(5'd9);
    n_checks++;
    if (bus.pend_cnt !== 6'd1) begin
      n_fail++; $display("FAIL reset_already_pending: got %0d expected 1", bus.pend_cnt);
    end
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd9;
    bus.wr_data[31:0] = 32'h67;
    step();
    idle();
    n_checks++;
    if (bus.pend_cnt !== 6'd0) begin
      n_fail++; $display("FAIL setclr_cleanup: got %0d expected 0", bus.pend_cnt);
    end
  endtask

  task automatic test_dual_clear();
    sb_mark(5'd10);
    sb_mark(5'd11);
    n_checks++;
    if (bus.pend_cnt !== 6'd2) begin
      n_fail++; $display("FAIL dual_setup: got %0d expected 2", bus.pend_cnt);
    end
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd11, 5'd10};
    bus.wr_data = {32'hB, 32'hA};
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd12;
    step();
    idle();
    bus.rd_addr = {5'd10, 5'd12};
    bus.rd_use  = 2'b11;
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd1 || bus.rd_busy !== 2'b01 || bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL dual_clear_net: got cnt %0d busy %b stall %b expected 1/01/1", bus.pend_cnt, bus.rd_busy, bus.stall);
    end
    n_checks++;
    if (bus.rd_data[63:32] !== 32'hA) begin
      n_fail++; $display("FAIL nonpending_write: got %h expected 0000000a", bus.rd_data[63:32]);
    end
    idle();
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd12;
    bus.wr_data[31:0] = 32'hC;
    step();
    idle();
    n_checks++;
    if (bus.pend_cnt !== 6'd0) begin
      n_fail++; $display("FAIL dual_cleanup: got %0d expected 0", bus.pend_cnt);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd1;
    bus.wr_data[31:0] = 32'hAB;
    step();
    sb_mark(5'd1);
    sb_mark(5'd2);
    sb_mark(5'd3);
    n_checks++;
    if (bus.pend_cnt !== 6'd3) begin
      n_fail++; $display("FAIL mid_setup: got %0d expected 3", bus.pend_cnt);
    end
    reset             = 1'b1;
    bus.sb_set        = 1'b1;
    bus.sb_addr       = 5'd4;
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd2;
    bus.wr_data[31:0] = 32'h77;
    step();
    reset = 1'b0;
    idle();
    bus.rd_addr = {5'd2, 5'd1};
    bus.rd_use  = 2'b11;
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd0 || bus.stall !== 1'b0 || bus.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_sb: got cnt %0d stall %b busy %b expected 0/0/00", bus.pend_cnt, bus.stall, bus.rd_busy);
    end
    n_checks++;
    if (bus.rd_data !== 64'h0) begin
      n_fail++; $display("FAIL mid_reset_data: got %h expected 0", bus.rd_data);
    end
    idle();
    bus.wr_en         = 2'b01;
    bus.wr_addr[4:0]  = 5'd2;
    bus.wr_data[31:0] = 32'h99;
    step();
    idle();
    bus.rd_addr[4:0] = 5'd2;
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd0 || bus.rd_data[31:0] !== 32'h99) begin
      n_fail++; $display("FAIL late_writeback: got cnt %0d data %h expected 0/00000099", bus.pend_cnt, bus.rd_data[31:0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_lane_priority();
    test_scoreboard();
    test_set_clear_same();
    test_dual_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
